// File: rtl/link_tx.sv
// Credit-based packet launcher: pops the local FIFO into a registered tx stage,
// gated by downstream credits and a halt handshake (RUN -> DRAIN -> HALTED).
module link_tx #(
  parameter int CREDITS   = 16,
  parameter int CNT_WIDTH = $clog2(CREDITS+1),
  parameter int PKT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [PKT_W-1:0]     fifo_dout,
  output logic                 fifo_rd_en,
  input  logic                 halt,
  input  logic                 credit_in,
  output logic                 tx_valid,
  output logic [PKT_W-1:0]     tx_data,
  output logic [CNT_WIDTH-1:0] credit_cnt,
  output logic                 halted,
  output logic                 credit_err,
  output logic [15:0]          sent_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t               state_q;
  logic                 tx_valid_q;
  logic [PKT_W-1:0]     tx_data_q;
  logic [CNT_WIDTH-1:0] credit_q, credit_d;
  logic                 err_q, halted_q, ovf;
  logic [15:0]          sent_q;
  logic                 launch;

  // rst gates the strobe so nothing is dequeued during a reset cycle
  assign launch = !rst && (state_q == RUN) && !halt && !fifo_empty &&
                  (credit_q != '0);

  always_comb begin
    credit_d = credit_q;
    ovf      = 1'b0;
    if (launch && !credit_in)
      credit_d = credit_q - CNT_WIDTH'(1);
    else if (!launch && credit_in) begin
      if (credit_q == CNT_WIDTH'(CREDITS)) ovf = 1'b1;
      else                                 credit_d = credit_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      credit_q   <= CNT_WIDTH'(CREDITS);
      err_q      <= 1'b0;
      sent_q     <= '0;
      halted_q   <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      if (ovf) err_q <= 1'b1;
      tx_valid_q <= launch;
      if (launch) begin
        tx_data_q <= fifo_dout;
        sent_q    <= sent_q + 16'd1;
      end
      // DRAIN exists only to let an in-flight packet leave before HALTED
      case (state_q)
        RUN: if (halt) begin
          state_q  <= tx_valid_q ? DRAIN : HALTED;
          halted_q <= !tx_valid_q;
        end
        DRAIN: begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end
        HALTED: if (!halt) begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = launch;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign credit_cnt = credit_q;
  assign halted     = halted_q;
  assign credit_err = err_q;
  assign sent_cnt   = sent_q;

endmodule

// File: tb/tb_link_tx.sv
// Bench for link_tx: directed vector table, random traffic against a
// transaction-level model, and an overflow sequence on a 16-credit instance.
module tb_link_tx;
  localparam int CR = 4;
  localparam int CW = $clog2(CR+1);

  logic clk = 0;
  always #5 clk = ~clk;

  logic          rst = 1, fifo_empty = 1, halt = 0, credit_in = 0;
  logic [31:0]   fifo_dout = '0;
  logic          fifo_rd_en, tx_valid, halted, credit_err;
  logic [31:0]   tx_data;
  logic [CW-1:0] credit_cnt;
  logic [15:0]   sent_cnt;

  link_tx #(.CREDITS(CR)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .halt(halt), .credit_in(credit_in),
    .tx_valid(tx_valid), .tx_data(tx_data), .credit_cnt(credit_cnt),
    .halted(halted), .credit_err(credit_err), .sent_cnt(sent_cnt));

  logic        rst2 = 1, cin2 = 0, empty2 = 1, halt2 = 0;
  logic [31:0] dout2 = '0;
  logic        rd2, txv2, hlt2, err2;
  logic [31:0] txd2;
  logic [4:0]  cnt2;
  logic [15:0] sent2;

  link_tx #(.CREDITS(16)) dut16 (
    .clk(clk), .rst(rst2), .fifo_empty(empty2), .fifo_dout(dout2),
    .fifo_rd_en(rd2), .halt(halt2), .credit_in(cin2),
    .tx_valid(txv2), .tx_data(txd2), .credit_cnt(cnt2),
    .halted(hlt2), .credit_err(err2), .sent_cnt(sent2));

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: packet queue plus counters; link mode 0=run 1=drain 2=halted
  logic [31:0] fq[$];
  int          m_mode = 0, m_cnt = CR, m_sent = 0;
  bit          m_err = 0, m_txv = 0;
  logic [31:0] m_txd = '0;
  int unsigned seq = 0;

  task automatic set_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = (fq.size() != 0) ? fq[0] : 32'h0;
  endtask

  task automatic push(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      fq.push_back(rnd ? $urandom : 32'hA000_0000 + seq);
      seq++;
    end
    set_fifo();
  endtask

  task automatic step();
    bit go;
    #2;
    go = !rst && m_mode == 0 && !halt && fq.size() != 0 && m_cnt != 0;
    check("fifo_rd_en", fifo_rd_en, go);
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_cnt = CR; m_sent = 0; m_err = 0; m_txv = 0; m_txd = '0;
    end else begin
      if (m_mode == 0 && halt) m_mode = m_txv ? 1 : 2;
      else if (m_mode == 1)    m_mode = 2;
      else if (m_mode == 2 && !halt) m_mode = 0;
      m_cnt = m_cnt - int'(go) + int'(credit_in);
      if (m_cnt > CR) begin m_cnt = CR; m_err = 1; end
      m_txv = go;
      if (go) begin
        m_txd  = fq.pop_front();
        m_sent = (m_sent + 1) % 65536;
      end
    end
    #1;
    check("tx_valid", tx_valid, m_txv);
    check("tx_data", tx_data, m_txd);
    check("credit_cnt", credit_cnt, m_cnt);
    check("credit_err", credit_err, m_err);
    check("sent_cnt", sent_cnt, m_sent);
    check("halted", halted, m_mode == 2);
    set_fifo();
  endtask

  typedef struct {
    bit rst, halt, cin; int push;
    bit rd, txv; int cnt, sent; bit hlt;
  } vec_t;
  vec_t tbl[22];

  task automatic tick2();
    @(posedge clk); #1;
  endtask

  initial begin
    // rst halt cin push | rd txv cnt sent halted
    tbl[0]  = '{1,0,0,0, 0,0,4,0,0};
    tbl[1]  = '{0,0,0,6, 1,1,3,1,0};  // burst of 4 on 4 credits
    tbl[2]  = '{0,0,0,0, 1,1,2,2,0};
    tbl[3]  = '{0,0,0,0, 1,1,1,3,0};
    tbl[4]  = '{0,0,0,0, 1,1,0,4,0};
    tbl[5]  = '{0,0,0,0, 0,0,0,4,0};
    tbl[6]  = '{0,0,1,0, 0,0,1,4,0};  // single credit return
    tbl[7]  = '{0,0,0,0, 1,1,0,5,0};
    tbl[8]  = '{0,0,0,0, 0,0,0,5,0};
    tbl[9]  = '{0,1,1,0, 0,0,1,5,1};  // halt while idle -> HALTED, credits accrue
    tbl[10] = '{0,1,1,0, 0,0,2,5,1};
    tbl[11] = '{0,0,0,0, 0,0,2,5,0};
    tbl[12] = '{0,0,1,0, 1,1,2,6,0};  // launch + credit at cnt=2
    tbl[13] = '{0,0,0,0, 0,0,2,6,0};
    tbl[14] = '{0,0,0,3, 1,1,1,7,0};
    tbl[15] = '{0,1,0,0, 0,0,1,7,0};  // halt mid-stream -> DRAIN
    tbl[16] = '{0,1,0,0, 0,0,1,7,1};
    tbl[17] = '{0,0,0,0, 0,0,1,7,0};
    tbl[18] = '{0,0,0,0, 1,1,0,8,0};
    tbl[19] = '{1,0,0,0, 0,0,4,0,0};  // reset with tx_valid=1
    tbl[20] = '{0,0,0,0, 1,1,3,1,0};
    tbl[21] = '{0,0,0,0, 0,0,3,1,0};

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].rst; halt = tbl[i].halt; credit_in = tbl[i].cin;
      push(tbl[i].push, 0);
      #1;
      check($sformatf("vec%0d rd_en", i), fifo_rd_en, tbl[i].rd);
      step();
      check($sformatf("vec%0d tx_valid", i), tx_valid, tbl[i].txv);
      check($sformatf("vec%0d credit_cnt", i), credit_cnt, tbl[i].cnt);
      check($sformatf("vec%0d sent_cnt", i), sent_cnt, tbl[i].sent);
      check($sformatf("vec%0d halted", i), halted, tbl[i].hlt);
    end

    halt = 0; credit_in = 0;
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) halt = !halt;
      credit_in = ($urandom_range(0, 2) == 0);
      if (fq.size() < 8 && $urandom_range(0, 1) == 1) push(1, 1);
      step();
    end

    // 16-credit instance: overflow is sticky until reset
    @(negedge clk);
    rst2 = 1; tick2();
    rst2 = 0; tick2();
    check("ovf cnt idle", cnt2, 16);
    check("ovf err idle", err2, 0);
    cin2 = 1; tick2();
    check("ovf cnt", cnt2, 16);
    check("ovf err set", err2, 1);
    cin2 = 0; tick2(); tick2();
    check("ovf err held", err2, 1);
    check("ovf cnt held", cnt2, 16);
    rst2 = 1; tick2();
    check("ovf err cleared", err2, 0);
    check("ovf rd_en", rd2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/link_tx.md
LINK_TX -- requirements
Module: link_tx

Interface
REQ-001 SHALL have parameter CREDITS, default 16, giving the downstream buffer depth (initial credit count); legal range 1..255.
REQ-002 SHALL have parameter CNT_WIDTH, default $clog2(CREDITS+1), giving the credit counter width.
REQ-003 SHALL have port clk  input  1  system clock; the only clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset, sampled on the rising clk edge.
REQ-005 SHALL have port fifo_empty  input  1  empty flag of the local packet_t FIFO.
REQ-006 SHALL have port fifo_dout  input  packet_t  head-of-FIFO packet, valid whenever fifo_empty=0.
REQ-007 SHALL have port fifo_rd_en  output  1  dequeue strobe to the local FIFO.
REQ-008 SHALL have port halt  input  1  request to stop launching packets.
REQ-009 SHALL have port credit_in  input  1  one-cycle pulse; one downstream slot freed.
REQ-010 SHALL have port tx_valid  output  1  tx_data carries a packet this cycle.
REQ-011 SHALL have port tx_data  output  packet_t  registered outgoing packet.
REQ-012 SHALL have port credit_cnt  output  CNT_WIDTH  current available credits.
REQ-013 SHALL have port halted  output  1  in HALTED state.
REQ-014 SHALL have port credit_err  output  1  sticky credit overflow error.
REQ-015 SHALL have port sent_cnt  output  16  packets launched, wraps modulo 2^16.

Function
REQ-016 SHALL implement FSM states RUN, DRAIN, HALTED; reset state is RUN.
REQ-017 SHALL define launch = (state==RUN) && !halt && !fifo_empty && (credit_cnt!=0).
REQ-018 SHALL drive fifo_rd_en = launch combinationally; it SHALL never assert while fifo_empty=1 or credit_cnt=0.
REQ-019 SHALL on a launch cycle register fifo_dout into tx_data and set tx_valid=1 on the next cycle (latency 1 cycle).
REQ-020 SHALL deassert tx_valid on the cycle after any non-launch cycle; tx_data SHALL hold its last value.
REQ-021 SHALL sustain one launch per cycle while the launch conditions hold.
REQ-022 SHALL update credits as credit_cnt_next = credit_cnt - launch + credit_in; a simultaneous launch and credit_in SHALL leave credit_cnt unchanged.
REQ-023 SHALL, when credit_in=1, launch=0 and credit_cnt==CREDITS, hold credit_cnt at CREDITS and set credit_err=1 until reset.
REQ-024 SHALL increment sent_cnt by 1 on each launch cycle, wrapping from 0xFFFF to 0.
REQ-025 SHALL transition RUN->DRAIN when halt=1 and tx_valid=1, and RUN->HALTED when halt=1 and tx_valid=0.
REQ-026 SHALL transition DRAIN->HALTED on the next cycle (in-flight packet delivered); DRAIN SHALL launch nothing.
REQ-027 SHALL transition HALTED->RUN when halt=0; the first launch SHALL occur in the cycle after the RUN state is entered.
REQ-028 SHALL assert halted=1 exactly while in HALTED; in HALTED, credit_in SHALL still be accumulated.

Reset
REQ-029 SHALL on rst=1 set state=RUN, tx_valid=0, tx_data='0, credit_cnt=CREDITS, credit_err=0, sent_cnt=0, halted=0.
REQ-030 SHALL drive fifo_rd_en=0 during any cycle with rst=1; a packet in flight at reset SHALL be discarded (tx_valid=0 after the reset edge).

Verification
REQ-031 SHALL cover burst: CREDITS=4, FIFO holds 6, no credit_in -> fifo_rd_en high for 4 consecutive cycles, 4 tx_valid pulses in order, credit_cnt=0, sent_cnt=4.
REQ-032 SHALL cover credit return: continuing REQ-031, a single credit_in pulse -> exactly 1 more launch, credit_cnt returns to 0, sent_cnt=5.
REQ-033 SHALL cover a simultaneous launch and credit_in at credit_cnt=2 -> credit_cnt stays 2, and a packet is launched.
REQ-034 SHALL cover overflow: idle with credit_cnt=16 plus credit_in -> credit_cnt=16, credit_err=1, held until rst.
REQ-035 SHALL cover halt mid-stream: halt=1 while tx_valid=1 -> one DRAIN cycle, then halted=1, no fifo_rd_en; halt=0 -> streaming resumes with no packet lost or duplicated.
REQ-036 SHALL cover reset mid-burst: rst=1 with tx_valid=1 -> next cycle tx_valid=0, credit_cnt=CREDITS, sent_cnt=0, state RUN.
